// File: rtl/aes_mix_add_round_key_nb_pkg.sv
// Shared types, constants and GF(2^8) helpers for the MixColumns/AddRoundKey stage.
package aes_mc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd01,
    StRd23,
    StCap,
    StWr01,
    StWr23,
    StDone
  } state_e;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [7:0]  GfPoly     = 8'h1B;
  localparam logic [31:0] LOCK_CONST = 32'hA5C3_5A3C;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GfPoly : 8'h00);
  endfunction

  // Only ever called with constant multipliers, so this folds to a small XOR network.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = b;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc ^= p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_mix_add_round_key_nb_if.sv
// Block handshake plus dual-port state memory bus for the mix/add-round-key stage.
interface aes_mix_add_round_key_nb_if #(
  parameter int unsigned NB     = 4,
  parameter int unsigned ADDR_W = $clog2(4 * NB)
) ();
  logic              ap_start;
  logic              ap_done;
  logic              ap_idle;
  logic              ap_ready;
  logic              inv;
  logic              final_rnd;
  logic [32*NB-1:0]  round_key;
  logic [ADDR_W-1:0] statemt_address0;
  logic              statemt_ce0;
  logic              statemt_we0;
  logic [31:0]       statemt_d0;
  logic [31:0]       statemt_q0;
  logic [ADDR_W-1:0] statemt_address1;
  logic              statemt_ce1;
  logic              statemt_we1;
  logic [31:0]       statemt_d1;
  logic [31:0]       statemt_q1;

  // Controller and state memory side.
  modport master (
    output ap_start, inv, final_rnd, round_key, statemt_q0, statemt_q1,
    input  ap_done, ap_idle, ap_ready,
    input  statemt_address0, statemt_ce0, statemt_we0, statemt_d0,
    input  statemt_address1, statemt_ce1, statemt_we1, statemt_d1
  );

  // Round stage side.
  modport slave (
    input  ap_start, inv, final_rnd, round_key, statemt_q0, statemt_q1,
    output ap_done, ap_idle, ap_ready,
    output statemt_address0, statemt_ce0, statemt_we0, statemt_d0,
    output statemt_address1, statemt_ce1, statemt_we1, statemt_d1
  );
endinterface

// File: rtl/aes_mix_add_round_key_nb_mix_col.sv
// Combinational MixColumns / InvMixColumns of one column; final_rnd passes bytes through.
module aes_mix_col
  import aes_mc_pkg::*;
(
  input  logic [3:0][7:0] col_in,
  input  logic            inv,
  input  logic            final_rnd,
  output logic [3:0][7:0] col_out
);

  logic [3:0][7:0] coef;

  // Row r multiplies col_in[(r+k)%4] by coef[k]: the matrix row rotated by r.
  always_comb begin
    coef    = inv ? {8'h09, 8'h0D, 8'h0B, 8'h0E} : {8'h01, 8'h01, 8'h03, 8'h02};
    col_out = '0;
    for (int r = 0; r < 4; r++) begin
      if (final_rnd) begin
        col_out[r] = col_in[r];
      end else begin
        for (int k = 0; k < 4; k++) begin
          col_out[r] ^= gmul(col_in[2'(r + k)], coef[k]);
        end
      end
    end
  end

endmodule

// File: rtl/aes_mix_add_round_key_nb.sv
// MixColumns/InvMixColumns + AddRoundKey over an NB-column state held in dual-port memory.
// Columns are mixed in place, two bytes read or written per cycle.
// Optional build macro LOCK_KEY_EN adds a locking_key input folded into every key column.
module aes_mix_add_round_key_nb
  import aes_mc_pkg::*;
#(
  parameter int unsigned NB     = 4,
  parameter int unsigned ADDR_W = $clog2(4 * NB)
) (
  input logic ap_clk,
  input logic ap_rst_n,
`ifdef LOCK_KEY_EN
  input logic [31:0] locking_key,
`endif
  aes_mix_add_round_key_nb_if.slave bus
);

  localparam int unsigned ColW = $clog2(NB);

  state_e            state_q;
  logic [ColW-1:0]   col_q;
  logic              inv_q;
  logic              final_q;
  logic [32*NB-1:0]  key_q;
  logic [3:0][7:0]   a_q;
  logic              done_q;
  logic              idle_q;
  logic              ce0_q, ce1_q, we0_q, we1_q;
  logic [ADDR_W-1:0] addr0_q, addr1_q;
  logic [7:0]        d0_q, d1_q;

  logic [3:0][7:0]   mix_in;
  logic [3:0][7:0]   mix_out;
  logic [3:0][7:0]   res;
  logic [31:0]       key_col;
  logic              unused_q;

  assign unused_q = ^{bus.statemt_q0[31:8], bus.statemt_q1[31:8]};

  // In CAP rows 2/3 are still on the read ports, so feed them straight in to have row 0/1
  // results ready for WR01.
  always_comb begin
    mix_in = a_q;
    if (state_q == StCap) begin
      mix_in[2] = bus.statemt_q0[7:0];
      mix_in[3] = bus.statemt_q1[7:0];
    end
  end

  aes_mix_col u_mix_col (
    .col_in   (mix_in),
    .inv      (inv_q),
    .final_rnd(final_q),
    .col_out  (mix_out)
  );

  // AddRoundKey on the current column.
  always_comb begin
    key_col = key_q[32*int'(col_q) +: 32];
`ifdef LOCK_KEY_EN
    key_col = key_col ^ locking_key ^ LOCK_CONST;
`endif
    for (int r = 0; r < 4; r++) begin
      res[r] = mix_out[r] ^ key_col[31-8*r -: 8];
    end
  end

  // Sequencer with registered memory strobes and handshake outputs.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= StIdle;
      col_q   <= '0;
      inv_q   <= 1'b0;
      final_q <= 1'b0;
      key_q   <= '0;
      a_q     <= '0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
      ce0_q   <= 1'b0;
      ce1_q   <= 1'b0;
      we0_q   <= 1'b0;
      we1_q   <= 1'b0;
      addr0_q <= '0;
      addr1_q <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
    end else begin
      done_q <= 1'b0;
      ce0_q  <= 1'b0;
      ce1_q  <= 1'b0;
      we0_q  <= 1'b0;
      we1_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.ap_start) begin
            state_q <= StRd01;
            idle_q  <= 1'b0;
            col_q   <= '0;
            inv_q   <= bus.inv;
            final_q <= bus.final_rnd;
            key_q   <= bus.round_key;
            ce0_q   <= 1'b1;
            ce1_q   <= 1'b1;
            addr0_q <= {{ColW{1'b0}}, 2'd0};
            addr1_q <= {{ColW{1'b0}}, 2'd1};
          end
        end
        StRd01: begin
          state_q <= StRd23;
          ce0_q   <= 1'b1;
          ce1_q   <= 1'b1;
          addr0_q <= {col_q, 2'd2};
          addr1_q <= {col_q, 2'd3};
        end
        StRd23: begin
          state_q <= StCap;
          a_q[0]  <= bus.statemt_q0[7:0];
          a_q[1]  <= bus.statemt_q1[7:0];
        end
        StCap: begin
          state_q <= StWr01;
          a_q[2]  <= bus.statemt_q0[7:0];
          a_q[3]  <= bus.statemt_q1[7:0];
          ce0_q   <= 1'b1;
          ce1_q   <= 1'b1;
          we0_q   <= 1'b1;
          we1_q   <= 1'b1;
          addr0_q <= {col_q, 2'd0};
          addr1_q <= {col_q, 2'd1};
          d0_q    <= res[0];
          d1_q    <= res[1];
        end
        StWr01: begin
          state_q <= StWr23;
          ce0_q   <= 1'b1;
          ce1_q   <= 1'b1;
          we0_q   <= 1'b1;
          we1_q   <= 1'b1;
          addr0_q <= {col_q, 2'd2};
          addr1_q <= {col_q, 2'd3};
          d0_q    <= res[2];
          d1_q    <= res[3];
        end
        StWr23: begin
          if (col_q == ColW'(NB - 1)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q <= StRd01;
            col_q   <= col_q + 1'b1;
            ce0_q   <= 1'b1;
            ce1_q   <= 1'b1;
            addr0_q <= {col_q + 1'b1, 2'd0};
            addr1_q <= {col_q + 1'b1, 2'd1};
          end
        end
        StDone: begin
          state_q <= StIdle;
          idle_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ap_done          = done_q;
  assign bus.ap_ready         = done_q;
  assign bus.ap_idle          = idle_q;
  assign bus.statemt_address0 = addr0_q;
  assign bus.statemt_ce0      = ce0_q;
  assign bus.statemt_we0      = we0_q;
  assign bus.statemt_d0       = {24'h0, d0_q};
  assign bus.statemt_address1 = addr1_q;
  assign bus.statemt_ce1      = ce1_q;
  assign bus.statemt_we1      = we1_q;
  assign bus.statemt_d1       = {24'h0, d1_q};

endmodule

// File: tb/tb_aes_mix_add_round_key_nb.sv
// Randomised bench for aes_mix_add_round_key_nb: NB=4 and NB=8 instances, each with a
// dual-port state memory model, checked against a matrix-form GF(2^8) reference model.
module tb_aes_mix_add_round_key_nb;
  import aes_mc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_mix_add_round_key_nb_if #(.NB(4)) bus4 ();
  aes_mix_add_round_key_nb_if #(.NB(8)) bus8 ();

`ifdef LOCK_KEY_EN
  logic [31:0] lock_key = LOCK_CONST;
`endif

  aes_mix_add_round_key_nb #(.NB(4)) u_dut4 (
    .ap_clk  (clk),
    .ap_rst_n(rst_n),
`ifdef LOCK_KEY_EN
    .locking_key(lock_key),
`endif
    .bus     (bus4)
  );

  aes_mix_add_round_key_nb #(.NB(8)) u_dut8 (
    .ap_clk  (clk),
    .ap_rst_n(rst_n),
`ifdef LOCK_KEY_EN
    .locking_key(lock_key),
`endif
    .bus     (bus8)
  );

  logic [7:0] mem4 [16];
  logic [7:0] mem8 [32];
  logic [7:0] pre  [32];
  logic [7:0] expm [32];
  bit         load_req = 1'b0;

  // State memories: 1-cycle read latency, junk in the upper q bits.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 16; i++) mem4[i] <= pre[i];
      for (int i = 0; i < 32; i++) mem8[i] <= pre[i];
    end else begin
      if (bus4.statemt_ce0) begin
        if (bus4.statemt_we0) mem4[bus4.statemt_address0] <= bus4.statemt_d0[7:0];
        bus4.statemt_q0 <= {24'hC0FFEE, mem4[bus4.statemt_address0]};
      end
      if (bus4.statemt_ce1) begin
        if (bus4.statemt_we1) mem4[bus4.statemt_address1] <= bus4.statemt_d1[7:0];
        bus4.statemt_q1 <= {24'hBEEF5A, mem4[bus4.statemt_address1]};
      end
      if (bus8.statemt_ce0) begin
        if (bus8.statemt_we0) mem8[bus8.statemt_address0] <= bus8.statemt_d0[7:0];
        bus8.statemt_q0 <= {24'h123456, mem8[bus8.statemt_address0]};
      end
      if (bus8.statemt_ce1) begin
        if (bus8.statemt_we1) mem8[bus8.statemt_address1] <= bus8.statemt_d1[7:0];
        bus8.statemt_q1 <= {24'hFEDCBA, mem8[bus8.statemt_address1]};
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Reference model: full matrices and polynomial long-division reduction.
  localparam logic [7:0] FWD_M [4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01},
                                          '{8'h01, 8'h02, 8'h03, 8'h01},
                                          '{8'h01, 8'h01, 8'h02, 8'h03},
                                          '{8'h03, 8'h01, 8'h01, 8'h02}};
  localparam logic [7:0] INV_M [4][4] = '{'{8'h0E, 8'h0B, 8'h0D, 8'h09},
                                          '{8'h09, 8'h0E, 8'h0B, 8'h0D},
                                          '{8'h0D, 8'h09, 8'h0E, 8'h0B},
                                          '{8'h0B, 8'h0D, 8'h09, 8'h0E}};

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_exp(input int nb, input bit inv, input bit fin, input logic [255:0] key);
    for (int c = 0; c < nb; c++) begin
      logic [31:0] kc;
      kc = key[32*c +: 32];
`ifdef LOCK_KEY_EN
      kc = kc ^ lock_key ^ LOCK_CONST;
`endif
      for (int r = 0; r < 4; r++) begin
        logic [7:0] acc;
        acc = '0;
        if (fin) acc = pre[4*c + r];
        else for (int k = 0; k < 4; k++)
          acc ^= gf_mul(pre[4*c + k], inv ? INV_M[r][k] : FWD_M[r][k]);
        expm[4*c + r] = acc ^ kc[31-8*r -: 8];
      end
    end
  endtask

  task automatic push_mem();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic rand_pre();
    for (int i = 0; i < 32; i++) pre[i] = 8'($urandom);
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  task automatic compare_mem(input int nb, input string tag);
    for (int i = 0; i < 4 * nb; i++) begin
      if (nb == 4) check_eq($sformatf("%s[%0d]", tag, i), 32'(mem4[i]), 32'(expm[i]));
      else         check_eq($sformatf("%s[%0d]", tag, i), 32'(mem8[i]), 32'(expm[i]));
    end
  endtask

  // Start one operation, scramble the operand inputs after the start cycle, wait for ap_done.
  task automatic run_op(input int nb, input bit inv, input bit fin, input logic [255:0] key,
                        input bit hold, output int lat, output bit wr31);
    bit prev;
    bit seen;
    @(negedge clk);
    if (nb == 4) begin
      bus4.inv = inv; bus4.final_rnd = fin; bus4.round_key = key[127:0]; bus4.ap_start = 1'b1;
    end else begin
      bus8.inv = inv; bus8.final_rnd = fin; bus8.round_key = key; bus8.ap_start = 1'b1;
    end
    lat = 0; prev = 1'b0; seen = 1'b0; wr31 = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus4.inv = ~inv; bus4.final_rnd = ~fin; bus4.round_key = ~key[127:0];
        bus8.inv = ~inv; bus8.final_rnd = ~fin; bus8.round_key = ~key;
        if (!hold) begin bus4.ap_start = 1'b0; bus8.ap_start = 1'b0; end
      end
      seen = (nb == 4) ? bus4.ap_done : bus8.ap_done;
      if (seen) begin
        check_eq("ready_with_done", 32'((nb == 4) ? bus4.ap_ready : bus8.ap_ready), 32'd1);
        wr31 = prev;
      end else begin
        prev = (nb == 8) && bus8.statemt_we1 && (bus8.statemt_address1 == 5'd31);
      end
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    if (hold) begin
      @(negedge clk);
      check_eq("idle_after_done", 32'(bus4.ap_idle), 32'd1);
      bus4.ap_start = 1'b0;
      @(negedge clk);
      check_eq("start_in_done_ignored", 32'(bus4.ap_idle), 32'd1);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int          lat;
    bit          wr31;
    bit          inv;
    bit          fin;
    logic [255:0] key;

    bus4.ap_start = 1'b0; bus4.inv = 1'b0; bus4.final_rnd = 1'b0; bus4.round_key = '0;
    bus8.ap_start = 1'b0; bus8.inv = 1'b0; bus8.final_rnd = 1'b0; bus8.round_key = '0;
    repeat (2) @(negedge clk);

    check_eq("rst_idle",  32'(bus4.ap_idle), 32'd1);
    check_eq("rst_done",  32'(bus4.ap_done), 32'd0);
    check_eq("rst_ready", 32'(bus4.ap_ready), 32'd0);
    check_eq("rst_ce",    32'({bus4.statemt_ce0, bus4.statemt_ce1}), 32'd0);
    check_eq("rst_we",    32'({bus4.statemt_we0, bus4.statemt_we1}), 32'd0);
    check_eq("rst_addr",  32'({bus4.statemt_address0, bus4.statemt_address1}), 32'd0);
    check_eq("rst_d",     bus4.statemt_d0 | bus4.statemt_d1, 32'd0);
    rst_n = 1'b1;

    // Known MixColumns vector, latency, and ap_start held through DONE.
    rand_pre();
    pre[0] = 8'hdb; pre[1] = 8'h13; pre[2] = 8'h53; pre[3] = 8'h45;
    push_mem();
    key = '0;
    build_exp(4, 1'b0, 1'b0, key);
    run_op(4, 1'b0, 1'b0, key, 1'b1, lat, wr31);
    check_eq("t1_latency", 32'(lat), 32'd21);
    check_eq("t1_col0", {mem4[0], mem4[1], mem4[2], mem4[3]}, 32'h8e4d_a1bc);
    compare_mem(4, "t1_mem");

    // Known InvMixColumns vectors.
    rand_pre();
    pre[0] = 8'h8e; pre[1] = 8'h4d; pre[2] = 8'ha1; pre[3] = 8'hbc;
    pre[4] = 8'h9f; pre[5] = 8'hdc; pre[6] = 8'h58; pre[7] = 8'h9d;
    push_mem();
    build_exp(4, 1'b1, 1'b0, key);
    run_op(4, 1'b1, 1'b0, key, 1'b0, lat, wr31);
    check_eq("t2_col0", {mem4[0], mem4[1], mem4[2], mem4[3]}, 32'hdb13_5345);
    check_eq("t2_col1", {mem4[4], mem4[5], mem4[6], mem4[7]}, 32'hf20a_225c);
    compare_mem(4, "t2_mem");

    // Final round: AddRoundKey only.
    for (int i = 0; i < 32; i++) pre[i] = 8'h00;
    push_mem();
    key = rand_key();
    key[31:0] = 32'h0001_0203;
    build_exp(4, 1'b0, 1'b1, key);
    run_op(4, 1'b0, 1'b1, key, 1'b0, lat, wr31);
    check_eq("t3_col0", {mem4[0], mem4[1], mem4[2], mem4[3]}, 32'h0001_0203);
    compare_mem(4, "t3_mem");

    // Random NB=4 operations.
    for (int it = 0; it < 4; it++) begin
      rand_pre(); push_mem();
      inv = 1'($urandom); fin = ($urandom_range(0, 3) == 0); key = rand_key();
      build_exp(4, inv, fin, key);
      run_op(4, inv, fin, key, 1'b0, lat, wr31);
      check_eq("r4_latency", 32'(lat), 32'd21);
      compare_mem(4, "r4_mem");
    end

    // Random NB=8 operations.
    for (int it = 0; it < 3; it++) begin
      rand_pre(); push_mem();
      inv = 1'(it); fin = (it == 2); key = rand_key();
      build_exp(8, inv, fin, key);
      run_op(8, inv, fin, key, 1'b0, lat, wr31);
      check_eq("r8_latency", 32'(lat), 32'd41);
      check_eq("r8_wr31_before_done", 32'(wr31), 32'd1);
      compare_mem(8, "r8_mem");
    end

    // Reset during WR01 of column 2, then restart.
    begin
      bit hit;
      rand_pre(); push_mem();
      key = rand_key();
      build_exp(4, 1'b0, 1'b0, key);
      @(negedge clk);
      bus4.inv = 1'b0; bus4.final_rnd = 1'b0; bus4.round_key = key[127:0]; bus4.ap_start = 1'b1;
      hit = 1'b0;
      for (int n = 0; n < 60 && !hit; n++) begin
        @(negedge clk);
        bus4.ap_start = 1'b0;
        hit = bus4.statemt_we0 && (bus4.statemt_address0 == 4'd8);
      end
      check_eq("t5_reached_wr01_col2", 32'(hit), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("t5_idle", 32'(bus4.ap_idle), 32'd1);
      check_eq("t5_no_strobe", 32'({bus4.statemt_ce0, bus4.statemt_we0, bus4.statemt_we1}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        if (i < 8) check_eq($sformatf("t5_done_col[%0d]", i), 32'(mem4[i]), 32'(expm[i]));
        else       check_eq($sformatf("t5_untouched[%0d]", i), 32'(mem4[i]), 32'(pre[i]));
      end
      for (int i = 0; i < 16; i++) pre[i] = mem4[i];
      key = rand_key();
      build_exp(4, 1'b1, 1'b0, key);
      run_op(4, 1'b1, 1'b0, key, 1'b0, lat, wr31);
      check_eq("t5_restart_latency", 32'(lat), 32'd21);
      compare_mem(4, "t5_restart_mem");
    end

`ifdef LOCK_KEY_EN
    // Correct locking key reproduces the plain result; a wrong one corrupts it.
    rand_pre();
    pre[0] = 8'hdb; pre[1] = 8'h13; pre[2] = 8'h53; pre[3] = 8'h45;
    push_mem();
    key = '0;
    lock_key = LOCK_CONST;
    run_op(4, 1'b0, 1'b0, key, 1'b0, lat, wr31);
    check_eq("t6_lock_ok", {mem4[0], mem4[1], mem4[2], mem4[3]}, 32'h8e4d_a1bc);
    push_mem();
    lock_key = 32'h0;
    build_exp(4, 1'b0, 1'b0, key);
    run_op(4, 1'b0, 1'b0, key, 1'b0, lat, wr31);
    check_eq("t6_lock_bad_differs",
             32'({mem4[0], mem4[1], mem4[2], mem4[3]} != 32'h8e4d_a1bc), 32'd1);
    compare_mem(4, "t6_lock_bad_mem");
    lock_key = LOCK_CONST;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
